// File: rtl/pulse_sync_feeder_if.sv
// Event/handshake bundle between local event logic, the feeder and the 4-bit pulse synchronizer.
interface pulse_sync_feeder_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]    evt_in;
  logic          evt_valid;
  logic          busy;
  logic [3:0]    sig_4bit;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          timeout_err;

  modport master (
    output evt_in, evt_valid, busy,
    input  sig_4bit, count, full, empty, overflow, timeout_err
  );

  modport slave (
    input  evt_in, evt_valid, busy,
    output sig_4bit, count, full, empty, overflow, timeout_err
  );
endinterface

// File: rtl/pulse_sync_feeder.sv
// Buffers 4-bit event codes and launches them one at a time as single-cycle pulses,
// waiting for a full busy rise/fall handshake from the synchronizer between launches.
module pulse_sync_feeder #(
  parameter int DEPTH     = 4,
  parameter int BUSY_WAIT = 4
) (
  input logic                clk,
  input logic                rst,
  pulse_sync_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    sig_q, sig_d;
  logic          full_q, empty_q, overflow_q, timeout_q;
  logic          pop, push, drop, evt_ok, timeout_set;

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    sig_d       = '0;
    pop         = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && !bus.busy) begin
          pop     = 1'b1;
          sig_d   = mem[rd_ptr];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        wait_d  = WW'(BUSY_WAIT);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.busy) begin
          state_d = WAIT_DONE;
        end else begin
          wait_d = wait_q - WW'(1);
          if (wait_q == WW'(1)) begin
            timeout_set = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A same-edge pop frees a slot, so a push into a full FIFO is legal then
    evt_ok = bus.evt_valid && (bus.evt_in != 4'h0);
    push   = evt_ok && (!full_q || pop);
    drop   = evt_ok && full_q && !pop;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      sig_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      sig_q   <= sig_d;
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
      if (push) begin
        mem[wr_ptr] <= bus.evt_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)         rd_ptr     <= rd_ptr + AW'(1);
      if (drop)        overflow_q <= 1'b1;
      if (timeout_set) timeout_q  <= 1'b1;
    end
  end

  assign bus.sig_4bit    = sig_q;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.empty       = empty_q;
  assign bus.overflow    = overflow_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_pulse_sync_feeder.sv
// Directed bench for pulse_sync_feeder with a simple synchronizer busy responder.
module tb_pulse_sync_feeder;
  localparam int DEPTH     = 4;
  localparam int BUSY_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_sync_feeder_if #(.DEPTH(DEPTH)) bus ();

  logic busy_force = 1'b0;
  logic busy_auto  = 1'b0;
  assign bus.busy = busy_force | busy_auto;

  pulse_sync_feeder #(.DEPTH(DEPTH), .BUSY_WAIT(BUSY_WAIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Responder: busy rises one cycle after a pulse and stays high busy_len cycles
  int         busy_len  = 3;
  int         busy_left = 0;
  bit         arm       = 1'b0;
  bit         prev_nz   = 1'b0;
  int         consec    = 0;
  logic [3:0] pulses[$];
  logic [3:0] exp_pulses[$];

  always @(negedge clk) begin
    if (busy_left > 0) begin
      busy_left = busy_left - 1;
      if (busy_left == 0) busy_auto = 1'b0;
    end
    if (arm) begin
      arm       = 1'b0;
      busy_auto = 1'b1;
      busy_left = busy_len;
    end
    if (bus.sig_4bit != 4'h0) begin
      pulses.push_back(bus.sig_4bit);
      if (busy_len > 0) arm = 1'b1;
      if (prev_nz) consec = consec + 1;
    end
    prev_nz = (bus.sig_4bit != 4'h0);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input logic [3:0] code);
    bus.evt_in    = code;
    bus.evt_valid = 1'b1;
    tick();
    bus.evt_valid = 1'b0;
    bus.evt_in    = 4'h0;
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
    check_val({tag, "_to"},  32'(bus.timeout_err), 32'd0);
  endtask

  int n0;

  initial begin
    bus.evt_in    = 4'h0;
    bus.evt_valid = 1'b0;

    rst = 1'b1;
    repeat (2) tick();
    check_val("rst_sig",   32'(bus.sig_4bit), 32'd0);
    check_val("rst_count", 32'(bus.count), 32'd0);
    check_val("rst_empty", 32'(bus.empty), 32'd1);
    check_val("rst_full",  32'(bus.full), 32'd0);
    check_flags("rst");
    rst = 1'b0;

    // Single event, minimum latency
    busy_len = 3;
    push_evt(4'h6);
    check_val("t1_count_push", 32'(bus.count), 32'd1);
    check_val("t1_sig_pre",    32'(bus.sig_4bit), 32'd0);
    tick();
    check_val("t1_sig",        32'(bus.sig_4bit), 32'h6);
    check_val("t1_count_pop",  32'(bus.count), 32'd0);
    tick();
    check_val("t1_sig_clear",  32'(bus.sig_4bit), 32'd0);
    repeat (8) tick();
    check_val("t1_empty", 32'(bus.empty), 32'd1);
    check_flags("t1");
    exp_pulses.push_back(4'h6);

    // Burst fills the FIFO while busy holds off launches
    busy_force = 1'b1;
    for (int i = 1; i <= 4; i++) push_evt(4'(i));
    check_val("t2_full",  32'(bus.full), 32'd1);
    check_val("t2_count", 32'(bus.count), 32'd4);
    busy_force = 1'b0;
    repeat (30) tick();
    check_val("t2_empty",     32'(bus.empty), 32'd1);
    check_val("t2_count_end", 32'(bus.count), 32'd0);
    check_flags("t2");
    for (int i = 1; i <= 4; i++) exp_pulses.push_back(4'(i));

    // Overflow drop, then push on the pop edge while full
    busy_force = 1'b1;
    for (int i = 11; i <= 14; i++) push_evt(4'(i));
    check_val("t3_full", 32'(bus.full), 32'd1);
    push_evt(4'h9);
    check_val("t3_drop_count", 32'(bus.count), 32'd4);
    check_val("t3_overflow",   32'(bus.overflow), 32'd1);
    busy_force    = 1'b0;
    bus.evt_in    = 4'hA;
    bus.evt_valid = 1'b1;
    tick();
    bus.evt_valid = 1'b0;
    bus.evt_in    = 4'h0;
    check_val("t3_pp_count", 32'(bus.count), 32'd4);
    check_val("t3_pp_full",  32'(bus.full), 32'd1);
    check_val("t3_pp_sig",   32'(bus.sig_4bit), 32'hB);
    repeat (40) tick();
    check_val("t3_empty", 32'(bus.empty), 32'd1);
    for (int i = 11; i <= 14; i++) exp_pulses.push_back(4'(i));
    exp_pulses.push_back(4'hA);

    // Zero code ignored; launch held off by busy
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t4_rst_ovf", 32'(bus.overflow), 32'd0);
    push_evt(4'h0);
    check_val("t4_zero_count", 32'(bus.count), 32'd0);
    check_val("t4_zero_empty", 32'(bus.empty), 32'd1);
    check_val("t4_zero_ovf",   32'(bus.overflow), 32'd0);
    n0 = pulses.size();
    busy_force = 1'b1;
    push_evt(4'h5);
    check_val("t4_count", 32'(bus.count), 32'd1);
    repeat (5) tick();
    check_val("t4_held_sig",    32'(bus.sig_4bit), 32'd0);
    check_val("t4_held_pulses", 32'(pulses.size()), 32'(n0));
    busy_force = 1'b0;
    tick();
    check_val("t4_launch_sig", 32'(bus.sig_4bit), 32'h5);
    repeat (10) tick();
    exp_pulses.push_back(4'h5);

    // Timeout with busy tied low
    busy_len = 0;
    push_evt(4'h7);
    push_evt(4'h8);
    check_val("t5_sig7", 32'(bus.sig_4bit), 32'h7);
    tick();
    repeat (3) tick();
    check_val("t5_to_early", 32'(bus.timeout_err), 32'd0);
    tick();
    check_val("t5_to_set", 32'(bus.timeout_err), 32'd1);
    check_val("t5_sig_to", 32'(bus.sig_4bit), 32'd0);
    tick();
    check_val("t5_sig8", 32'(bus.sig_4bit), 32'h8);
    repeat (8) tick();
    check_val("t5_to_sticky", 32'(bus.timeout_err), 32'd1);
    exp_pulses.push_back(4'h7);
    exp_pulses.push_back(4'h8);

    // Reset while in WAIT_DONE with entries queued
    busy_len = 8;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    busy_force = 1'b1;
    for (int i = 1; i <= 3; i++) push_evt(4'(i));
    busy_force = 1'b0;
    tick();
    check_val("t6_sig1",   32'(bus.sig_4bit), 32'h1);
    repeat (3) tick();
    check_val("t6_queued", 32'(bus.count), 32'd2);
    rst           = 1'b1;
    bus.evt_in    = 4'hF;
    bus.evt_valid = 1'b1;
    tick();
    rst           = 1'b0;
    bus.evt_valid = 1'b0;
    bus.evt_in    = 4'h0;
    check_val("t6_count", 32'(bus.count), 32'd0);
    check_val("t6_sig",   32'(bus.sig_4bit), 32'd0);
    check_val("t6_empty", 32'(bus.empty), 32'd1);
    check_val("t6_full",  32'(bus.full), 32'd0);
    check_flags("t6");
    n0 = pulses.size();
    repeat (20) tick();
    check_val("t6_no_pulse", 32'(pulses.size()), 32'(n0));
    exp_pulses.push_back(4'h1);

    check_val("pulse_consecutive", 32'(consec), 32'd0);
    check_val("pulse_total", 32'(pulses.size()), 32'(exp_pulses.size()));
    for (int i = 0; i < exp_pulses.size() && i < pulses.size(); i++)
      check_val($sformatf("pulse_%0d", i), 32'(pulses[i]), 32'(exp_pulses[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
